// File: rtl/fight_round_controller_if.sv
// Player action interface between the round controller (master), the
// keypad/decoder front end and the two player FSMs (slave side).
interface fight_round_controller_if;
    logic       p1_valid;
    logic [2:0] p1_action;
    logic       p2_valid;
    logic [2:0] p2_action;
    logic [1:0] health1;
    logic [1:0] health2;
    logic [2:0] action1;
    logic [2:0] action2;
    logic       actionEnable;
    logic       isGameOver;
    logic [1:0] winner;
    logic [7:0] round_count;

    modport master (
        input  p1_valid, p1_action, p2_valid, p2_action, health1, health2,
        output action1, action2, actionEnable, isGameOver, winner, round_count
    );

    modport slave (
        output p1_valid, p1_action, p2_valid, p2_action, health1, health2,
        input  action1, action2, actionEnable, isGameOver, winner, round_count
    );
endinterface

// File: rtl/fight_round_controller.sv
// Collects one action per player per round, strobes actionEnable, then judges health.
// Optional macro ROUND_LIMIT_EN ends the game after MAX_ROUNDS rounds, judged on health.
module fight_round_controller #(
    parameter int EN_CYCLES  = 2,
    parameter int TIMEOUT    = 16,
    parameter int MAX_ROUNDS = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    fight_round_controller_if.master  bus
);

    typedef enum logic [2:0] {COLLECT, ENABLE, RELEASE, CHECK, OVER} state_t;

    localparam logic [2:0] ACT_AWAIT = 3'b010;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int EW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [EW-1:0] EN_LAST    = EW'((EN_CYCLES > 0) ? EN_CYCLES - 1 : 0);

    if (EN_CYCLES < 1) begin : g_bad_en_cycles
        $error("EN_CYCLES must be at least 1");
    end
    if (MAX_ROUNDS < 1 || MAX_ROUNDS > 255) begin : g_bad_max_rounds
        $error("MAX_ROUNDS must be in 1..255");
    end

    state_t        state;
    logic          got1, got2;
    logic [TW-1:0] timer;
    logic [EW-1:0] en_cnt;

    logic       h1_alive, h2_alive, missing_valid;
    logic [7:0] rc_next;

    // Wrapped health (e.g. 11 after underflow) still counts as alive.
    assign h1_alive      = (bus.health1 != 2'b00);
    assign h2_alive      = (bus.health2 != 2'b00);
    assign missing_valid = got1 ? bus.p2_valid : bus.p1_valid;
    assign rc_next       = (bus.round_count == 8'hFF) ? bus.round_count : bus.round_count + 8'd1;

    // NOTE: all state and outputs use non-blocking assignments under an async
    // reset so every register updates from pre-edge values and actionEnable
    // drops the moment reset asserts, without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= COLLECT;
            got1             <= 1'b0;
            got2             <= 1'b0;
            timer            <= '0;
            en_cnt           <= '0;
            bus.action1      <= ACT_AWAIT;
            bus.action2      <= ACT_AWAIT;
            bus.actionEnable <= 1'b0;
            bus.isGameOver   <= 1'b0;
            bus.winner       <= 2'b00;
            bus.round_count  <= 8'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (got1 && got2) begin
                        state            <= ENABLE;
                        bus.actionEnable <= 1'b1;
                        en_cnt           <= '0;
                    end else begin
                        if (bus.p1_valid) begin
                            bus.action1 <= bus.p1_action;
                            got1        <= 1'b1;
                        end
                        if (bus.p2_valid) begin
                            bus.action2 <= bus.p2_action;
                            got2        <= 1'b1;
                        end
                        if (!got1 && !got2) begin
                            if (bus.p1_valid || bus.p2_valid) timer <= '0;
                        end else if (TIMEOUT != 0) begin
                            // A late valid from the missing player beats the timeout.
                            if (!missing_valid && timer == TIMER_LAST) begin
                                if (got1) begin
                                    bus.action2 <= ACT_AWAIT;
                                    got2        <= 1'b1;
                                end else begin
                                    bus.action1 <= ACT_AWAIT;
                                    got1        <= 1'b1;
                                end
                                state            <= ENABLE;
                                bus.actionEnable <= 1'b1;
                                en_cnt           <= '0;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                end

                ENABLE: begin
                    if (en_cnt == EN_LAST) begin
                        state            <= RELEASE;
                        bus.actionEnable <= 1'b0;
                    end else begin
                        en_cnt <= en_cnt + 1'b1;
                    end
                end

                RELEASE: state <= CHECK;

                CHECK: begin
                    bus.round_count <= rc_next;
                    got1            <= 1'b0;
                    got2            <= 1'b0;
                    timer           <= '0;
                    if (!h1_alive || !h2_alive) begin
                        state          <= OVER;
                        bus.isGameOver <= 1'b1;
                        bus.winner     <= {!h1_alive, !h2_alive};
                    end
`ifdef ROUND_LIMIT_EN
                    else if (rc_next == 8'(MAX_ROUNDS)) begin
                        state          <= OVER;
                        bus.isGameOver <= 1'b1;
                        if (bus.health1 > bus.health2)      bus.winner <= 2'b01;
                        else if (bus.health2 > bus.health1) bus.winner <= 2'b10;
                        else                                bus.winner <= 2'b11;
                    end
`endif
                    else begin
                        state <= COLLECT;
                    end
                end

                OVER: begin
                    bus.actionEnable <= 1'b0;
                    bus.isGameOver   <= 1'b1;
                end

                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_fight_round_controller.sv
// Directed, table-driven bench for fight_round_controller (EN_CYCLES=2, TIMEOUT=16, MAX_ROUNDS=3).
module tb_fight_round_controller;

    typedef struct {
        logic       v1;
        logic [2:0] a1;
        logic       v2;
        logic [2:0] a2;
        logic [1:0] h1;
        logic [1:0] h2;
        logic [2:0] e_a1;
        logic [2:0] e_a2;
        logic       e_en;
        logic       e_over;
        logic [1:0] e_win;
        logic [7:0] e_rc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    fight_round_controller_if bus ();

    fight_round_controller #(
        .EN_CYCLES (2),
        .TIMEOUT   (16),
        .MAX_ROUNDS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic v1, input logic [2:0] a1, input logic v2,
                                input logic [2:0] a2, input logic [1:0] h1, input logic [1:0] h2,
                                input logic [2:0] e_a1, input logic [2:0] e_a2, input logic e_en,
                                input logic e_over, input logic [1:0] e_win, input logic [7:0] e_rc);
        vec_t v;
        v.v1 = v1; v.a1 = a1; v.v2 = v2; v.a2 = a2; v.h1 = h1; v.h2 = h2;
        v.e_a1 = e_a1; v.e_a2 = e_a2; v.e_en = e_en; v.e_over = e_over;
        v.e_win = e_win; v.e_rc = e_rc;
        return v;
    endfunction

    function automatic logic [17:0] observed();
        return {bus.action1, bus.action2, bus.actionEnable, bus.isGameOver, bus.winner, bus.round_count};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got a1=%b a2=%b en=%b over=%b win=%b rc=%0d, expected a1=%b a2=%b en=%b over=%b win=%b rc=%0d",
                     name, act[17:15], act[14:12], act[11], act[10], act[9:8], act[7:0],
                     exp[17:15], exp[14:12], exp[11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and compare the registered outputs.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        bus.p1_valid  = v.v1;
        bus.p1_action = v.a1;
        bus.p2_valid  = v.v2;
        bus.p2_action = v.a2;
        bus.health1   = v.h1;
        bus.health2   = v.h2;
        @(posedge clk);
        #1;
        check(name, observed(), {v.e_a1, v.e_a2, v.e_en, v.e_over, v.e_win, v.e_rc});
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset        = 1'b0;
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        bus.health1  = 2'b11;
        bus.health2  = 2'b11;
        #1;
        check(name, observed(), {3'b010, 3'b010, 1'b0, 1'b0, 2'b00, 8'd0});
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One full round with alive healths: valid step, 2 enable, release, check, collect.
    task automatic play_round(input logic [1:0] h1, input logic [1:0] h2, input logic [7:0] rc,
                              input logic e_over, input logic [1:0] e_win, input string name);
        apply(mk(1, 3'b000, 1, 3'b000, h1, h2, 3'b000, 3'b000, 0, 0, 2'b00, rc), {name, "_latch"});
        apply(mk(0, 3'b000, 0, 3'b000, h1, h2, 3'b000, 3'b000, 1, 0, 2'b00, rc), {name, "_en1"});
        apply(mk(0, 3'b000, 0, 3'b000, h1, h2, 3'b000, 3'b000, 1, 0, 2'b00, rc), {name, "_en2"});
        apply(mk(0, 3'b000, 0, 3'b000, h1, h2, 3'b000, 3'b000, 0, 0, 2'b00, rc), {name, "_release"});
        apply(mk(0, 3'b000, 0, 3'b000, h1, h2, 3'b000, 3'b000, 0, 0, 2'b00, rc), {name, "_check"});
        apply(mk(0, 3'b000, 0, 3'b000, h1, h2, 3'b000, 3'b000, 0, e_over, e_win, rc + 8'd1), {name, "_done"});
    endtask

    vec_t table_v[23];

    initial begin
        bus.p1_valid  = 1'b0;
        bus.p1_action = 3'b000;
        bus.p2_valid  = 1'b0;
        bus.p2_action = 3'b000;
        bus.health1   = 2'b11;
        bus.health2   = 2'b11;

        //                v1 a1      v2 a2      h1 h2   e_a1    e_a2   en ov win    rc
        table_v[0]  = mk(1, 3'b000, 1, 3'b001, 3, 3, 3'b000, 3'b001, 0, 0, 2'b00, 0);
        table_v[1]  = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b000, 3'b001, 1, 0, 2'b00, 0);
        table_v[2]  = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b000, 3'b001, 1, 0, 2'b00, 0);
        table_v[3]  = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b000, 3'b001, 0, 0, 2'b00, 0);
        table_v[4]  = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b000, 3'b001, 0, 0, 2'b00, 0);
        table_v[5]  = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b000, 3'b001, 0, 0, 2'b00, 1);
        table_v[6]  = mk(1, 3'b000, 0, 3'b000, 3, 3, 3'b000, 3'b001, 0, 0, 2'b00, 1);
        table_v[7]  = mk(1, 3'b011, 0, 3'b000, 3, 3, 3'b011, 3'b001, 0, 0, 2'b00, 1);
        table_v[8]  = mk(0, 3'b000, 1, 3'b110, 3, 3, 3'b011, 3'b110, 0, 0, 2'b00, 1);
        table_v[9]  = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b011, 3'b110, 1, 0, 2'b00, 1);
        table_v[10] = mk(1, 3'b101, 1, 3'b000, 3, 3, 3'b011, 3'b110, 1, 0, 2'b00, 1);
        table_v[11] = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b011, 3'b110, 0, 0, 2'b00, 1);
        table_v[12] = mk(1, 3'b100, 0, 3'b000, 3, 3, 3'b011, 3'b110, 0, 0, 2'b00, 1);
        table_v[13] = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b011, 3'b110, 0, 0, 2'b00, 2);
        table_v[14] = mk(1, 3'b001, 1, 3'b000, 3, 3, 3'b001, 3'b000, 0, 0, 2'b00, 2);
        table_v[15] = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b001, 3'b000, 1, 0, 2'b00, 2);
        table_v[16] = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b001, 3'b000, 1, 0, 2'b00, 2);
        table_v[17] = mk(0, 3'b000, 0, 3'b000, 1, 0, 3'b001, 3'b000, 0, 0, 2'b00, 2);
        table_v[18] = mk(0, 3'b000, 0, 3'b000, 1, 0, 3'b001, 3'b000, 0, 0, 2'b00, 2);
        table_v[19] = mk(0, 3'b000, 0, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1, 2'b01, 3);
        table_v[20] = mk(1, 3'b011, 1, 3'b011, 1, 0, 3'b001, 3'b000, 0, 1, 2'b01, 3);
        table_v[21] = mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b001, 3'b000, 0, 1, 2'b01, 3);
        table_v[22] = mk(0, 3'b000, 1, 3'b111, 3, 3, 3'b001, 3'b000, 0, 1, 2'b01, 3);

        do_reset("reset_values");
        for (int i = 0; i < 23; i++) apply(table_v[i], $sformatf("table_%0d", i));

        // Timeout: p2 silent after p1 submits; a2 starts non-await so the force is visible.
        do_reset("reset_before_timeout");
        play_round(3, 3, 0, 0, 2'b00, "pre_timeout");
        apply(mk(1, 3'b100, 0, 3'b000, 3, 3, 3'b100, 3'b000, 0, 0, 2'b00, 1), "timeout_p1_submit");
        for (int k = 1; k < 16; k++)
            apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b100, 3'b000, 0, 0, 2'b00, 1),
                  $sformatf("timeout_wait_%0d", k));
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b100, 3'b010, 1, 0, 2'b00, 1), "timeout_fire");
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b100, 3'b010, 1, 0, 2'b00, 1), "timeout_en2");
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b100, 3'b010, 0, 0, 2'b00, 1), "timeout_release");
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b100, 3'b010, 0, 0, 2'b00, 1), "timeout_check");
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b100, 3'b010, 0, 0, 2'b00, 2), "timeout_round_done");

        // Both players dead in the same round: draw.
        apply(mk(1, 3'b010, 1, 3'b011, 3, 3, 3'b010, 3'b011, 0, 0, 2'b00, 2), "draw_latch");
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b010, 3'b011, 1, 0, 2'b00, 2), "draw_en1");
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b010, 3'b011, 1, 0, 2'b00, 2), "draw_en2");
        apply(mk(0, 3'b000, 0, 3'b000, 0, 0, 3'b010, 3'b011, 0, 0, 2'b00, 2), "draw_release");
        apply(mk(0, 3'b000, 0, 3'b000, 0, 0, 3'b010, 3'b011, 0, 0, 2'b00, 2), "draw_check");
        apply(mk(0, 3'b000, 0, 3'b000, 0, 0, 3'b010, 3'b011, 0, 1, 2'b11, 3), "draw_over");

        // New game, then reset asserted while actionEnable is high.
        do_reset("reset_new_game");
        apply(mk(1, 3'b001, 1, 3'b011, 3, 3, 3'b001, 3'b011, 0, 0, 2'b00, 0), "midreset_latch");
        apply(mk(0, 3'b000, 0, 3'b000, 3, 3, 3'b001, 3'b011, 1, 0, 2'b00, 0), "midreset_enable");
        #2;
        reset = 1'b0;
        #1;
        check("midreset_async", observed(), {3'b010, 3'b010, 1'b0, 1'b0, 2'b00, 8'd0});
        @(negedge clk);
        reset = 1'b1;

        // Alive healths 11 vs 10 for three rounds: ends the game only with the round limit.
        do_reset("reset_before_limit");
        play_round(3, 2, 0, 0, 2'b00, "limit_r1");
        play_round(3, 2, 1, 0, 2'b00, "limit_r2");
`ifdef ROUND_LIMIT_EN
        play_round(3, 2, 2, 1, 2'b01, "limit_r3");
        apply(mk(1, 3'b111, 1, 3'b111, 3, 2, 3'b000, 3'b000, 0, 1, 2'b01, 3), "limit_over_ignores");
`else
        play_round(3, 2, 2, 0, 2'b00, "nolimit_r3");
        apply(mk(1, 3'b111, 1, 3'b101, 3, 2, 3'b111, 3'b101, 0, 0, 2'b00, 3), "nolimit_collects");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
